// File: rtl/vram_arbiter.sv
// VRAM port arbiter: fixed-slot video reads win the bus, and snooped CPU writes
// are posted into a circular FIFO that drains one entry per cycle outside read slots.
module vram_arbiter #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 8,
  parameter int NUM_BUF    = 2,
  parameter int BSEL_W     = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1,
  parameter int FIFO_DEPTH = 4,
  parameter int SEQ_W      = 3,
  parameter int VID_SLOT   = 0
) (
  input  logic              pixClk,
  input  logic              nReset,
  input  logic [SEQ_W-1:0]  seq,
  input  logic              vidReq,
  input  logic [ADDR_W-1:0] vidAddr,
  input  logic [BSEL_W-1:0] vidBufSel,
  output logic [DATA_W-1:0] vidData,
  output logic              vidValid,
  input  logic              wrValid,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic [BSEL_W-1:0] wrBuf,
  output logic              wrReady,
  output logic              wrOverflow,
  output logic [ADDR_W-1:0] vramAddr,
  output logic [DATA_W-1:0] vramDout,
  input  logic [DATA_W-1:0] vramDin,
  output logic              vramDoe,
  output logic              nvramOE,
  output logic              nvramWE,
  output logic [NUM_BUF-1:0] nvramCE
);

  localparam int PTR_W = $clog2(FIFO_DEPTH) + 1;
  localparam int IDX_W = PTR_W - 1;

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t r_state;
  state_t w_state_next;

  logic [ADDR_W-1:0] r_mem_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] r_mem_data [FIFO_DEPTH];
  logic [BSEL_W-1:0] r_mem_buf  [FIFO_DEPTH];

  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   w_count;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic [ADDR_W-1:0]  w_head_addr;
  logic [DATA_W-1:0]  w_head_data;
  logic [BSEL_W-1:0]  w_head_buf;
  logic [NUM_BUF-1:0] w_rd_ce_n;
  logic [NUM_BUF-1:0] w_wr_ce_n;

  logic               r_in_write;
  logic               r_overflow;
  logic [ADDR_W-1:0]  r_vram_addr;
  logic [DATA_W-1:0]  r_vram_dout;
  logic               r_vram_doe;
  logic               r_oe_n;
  logic [NUM_BUF-1:0] r_ce_n;
  logic [DATA_W-1:0]  r_vid_data;
  logic               r_vid_valid;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign w_count     = r_wr_ptr - r_rd_ptr;
  assign w_empty     = (w_count == '0);
  assign wrReady     = (w_count != PTR_W'(FIFO_DEPTH));
  assign w_push      = wrValid & wrReady;
  assign w_pop       = (w_state_next == WRITE);
  assign w_head_addr = r_mem_addr[r_rd_ptr[IDX_W-1:0]];
  assign w_head_data = r_mem_data[r_rd_ptr[IDX_W-1:0]];
  assign w_head_buf  = r_mem_buf[r_rd_ptr[IDX_W-1:0]];

  // Out-of-range buffer selects match no bit, so no chip is enabled.
  for (genvar gi = 0; gi < NUM_BUF; gi++) begin : g_ce
    assign w_rd_ce_n[gi] = (vidBufSel != BSEL_W'(gi));
    assign w_wr_ce_n[gi] = (w_head_buf != BSEL_W'(gi));
  end

  always_comb begin
    w_state_next = IDLE;
    if (vidReq && (seq == SEQ_W'(VID_SLOT))) begin
      w_state_next = READ;
    end else if (!w_empty) begin
      w_state_next = WRITE;
    end
  end

  always_ff @(posedge pixClk) begin
    if (w_push) begin
      r_mem_addr[r_wr_ptr[IDX_W-1:0]] <= wrAddr;
      r_mem_data[r_wr_ptr[IDX_W-1:0]] <= wrData;
      r_mem_buf[r_wr_ptr[IDX_W-1:0]]  <= wrBuf;
    end
  end

  always_ff @(posedge pixClk or negedge nReset) begin
    if (!nReset) begin
      r_state     <= IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_overflow  <= 1'b0;
      r_in_write  <= 1'b0;
      r_vram_addr <= '0;
      r_vram_dout <= '0;
      r_vram_doe  <= 1'b0;
      r_oe_n      <= 1'b1;
      r_ce_n      <= '1;
      r_vid_data  <= '0;
      r_vid_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (wrValid && !wrReady) r_overflow <= 1'b1;
      // The closing edge of a READ cycle captures the bus.
      if (r_state == READ) r_vid_data <= vramDin;
      r_vid_valid <= (r_state == READ);
      r_in_write  <= w_pop;
      r_vram_doe  <= w_pop;
      r_oe_n      <= (w_state_next != READ);
      case (w_state_next)
        READ: begin
          r_vram_addr <= vidAddr;
          r_ce_n      <= w_rd_ce_n;
        end
        WRITE: begin
          r_vram_addr <= w_head_addr;
          r_vram_dout <= w_head_data;
          r_ce_n      <= w_wr_ce_n;
        end
        default: begin
          r_vram_addr <= '0;
          r_ce_n      <= '1;
        end
      endcase
    end
  end

  // Strobe only in the low half so address and data settle around it.
  assign nvramWE    = ~r_in_write | pixClk;
  assign nvramOE    = r_oe_n;
  assign nvramCE    = r_ce_n;
  assign vramAddr   = r_vram_addr;
  assign vramDout   = r_vram_dout;
  assign vramDoe    = r_vram_doe;
  assign vidData    = r_vid_data;
  assign vidValid   = r_vid_valid;
  assign wrOverflow = r_overflow;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: default 8-bit/2-chip instance plus a 16-bit/4-chip instance.
module tb_vram_arbiter;
  localparam logic [2:0] SLOT = 3'd0;

  logic        pixClk = 1'b0;
  logic        nReset = 1'b0;
  logic [2:0]  seq = 3'd5;
  logic        vidReq = 1'b0;
  logic [14:0] vidAddr = '0;
  logic        vidBufSel = 1'b0;
  logic [7:0]  vidData;
  logic        vidValid;
  logic        wrValid = 1'b0;
  logic [14:0] wrAddr = '0;
  logic [7:0]  wrData = '0;
  logic        wrBuf = 1'b0;
  logic        wrReady, wrOverflow;
  logic [14:0] vramAddr;
  logic [7:0]  vramDout;
  logic [7:0]  vramDin = '0;
  logic        vramDoe, nvramOE, nvramWE;
  logic [1:0]  nvramCE;

  logic        b_wrValid = 1'b0;
  logic [14:0] b_wrAddr = '0;
  logic [15:0] b_wrData = '0;
  logic [1:0]  b_wrBuf = '0;
  logic [15:0] b_vidData;
  logic        b_vidValid, b_wrReady, b_wrOverflow;
  logic [14:0] b_vramAddr;
  logic [15:0] b_vramDout;
  logic        b_vramDoe, b_nvramOE, b_nvramWE;
  logic [3:0]  b_nvramCE;

  int total = 0;
  int bad = 0;

  always #10 pixClk = ~pixClk;

  vram_arbiter u_dut (
    .pixClk(pixClk), .nReset(nReset), .seq(seq), .vidReq(vidReq),
    .vidAddr(vidAddr), .vidBufSel(vidBufSel), .vidData(vidData), .vidValid(vidValid),
    .wrValid(wrValid), .wrAddr(wrAddr), .wrData(wrData), .wrBuf(wrBuf),
    .wrReady(wrReady), .wrOverflow(wrOverflow), .vramAddr(vramAddr),
    .vramDout(vramDout), .vramDin(vramDin), .vramDoe(vramDoe),
    .nvramOE(nvramOE), .nvramWE(nvramWE), .nvramCE(nvramCE)
  );

  vram_arbiter #(.DATA_W(16), .NUM_BUF(4)) u_dut4 (
    .pixClk(pixClk), .nReset(nReset), .seq(3'd5), .vidReq(1'b0),
    .vidAddr(15'd0), .vidBufSel(2'd0), .vidData(b_vidData), .vidValid(b_vidValid),
    .wrValid(b_wrValid), .wrAddr(b_wrAddr), .wrData(b_wrData), .wrBuf(b_wrBuf),
    .wrReady(b_wrReady), .wrOverflow(b_wrOverflow), .vramAddr(b_vramAddr),
    .vramDout(b_vramDout), .vramDin(16'd0), .vramDoe(b_vramDoe),
    .nvramOE(b_nvramOE), .nvramWE(b_nvramWE), .nvramCE(b_nvramCE)
  );

  task automatic tick;
    @(posedge pixClk);
    #1;
  endtask

  task automatic idle_inputs;
    vidReq = 1'b0;
    seq = 3'd5;
    wrValid = 1'b0;
    b_wrValid = 1'b0;
  endtask

  task automatic pulse_reset;
    nReset = 1'b0;
    #3;
    nReset = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    logic [40:0] got;
    logic [40:0] exp;
    nReset = 1'b0;
    exp = {15'd0, 8'd0, 1'b0, 1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 8'd0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      seq = 3'(i); vidReq = 1'b1; wrValid = 1'b1; wrAddr = 15'(i + 7);
      vidBufSel = 1'(i % 2); vramDin = 8'(8'h40 + i);
      tick();
      got = {vramAddr, vramDout, vramDoe, nvramOE, nvramWE, nvramCE,
             wrReady, wrOverflow, vidData, vidValid};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL reset_hold[%0d] got=%h expected=%h", i, got, exp);
      end
    end
    idle_inputs();
    nReset = 1'b1;
    tick();
    total++;
    if ({nvramCE, vramDoe, wrReady, wrOverflow} !== {2'b11, 1'b0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL reset_release got=%b expected=%b",
               {nvramCE, vramDoe, wrReady, wrOverflow}, 5'b11010);
    end
  endtask

  task automatic test_single_write;
    wrValid = 1'b1; wrAddr = 15'h1234; wrData = 8'hA5; wrBuf = 1'b1;
    tick();
    wrValid = 1'b0;
    tick();
    total++;
    if ({vramAddr, vramDout, vramDoe, nvramOE, nvramCE} !== {15'h1234, 8'hA5, 1'b1, 1'b1, 2'b01}) begin
      bad++;
      $display("FAIL single_write bus got addr=%h dout=%h doe=%b oe=%b ce=%b expected 1234/a5/1/1/01",
               vramAddr, vramDout, vramDoe, nvramOE, nvramCE);
    end else $display("write 1234 <= a5 buf1 seen");
    total++;
    if (nvramWE !== 1'b1) begin
      bad++;
      $display("FAIL single_write we_high_half got=%b expected=1", nvramWE);
    end
    @(negedge pixClk); #1;
    total++;
    if ({nvramWE, vramAddr, vramDout} !== {1'b0, 15'h1234, 8'hA5}) begin
      bad++;
      $display("FAIL single_write we_low_half got we=%b addr=%h dout=%h expected 0/1234/a5",
               nvramWE, vramAddr, vramDout);
    end
    tick();
    total++;
    if ({vramAddr, vramDoe, nvramOE, nvramWE, nvramCE} !== {15'd0, 1'b0, 1'b1, 1'b1, 2'b11}) begin
      bad++;
      $display("FAIL single_write idle_after got addr=%h doe=%b oe=%b we=%b ce=%b expected 0/0/1/1/11",
               vramAddr, vramDoe, nvramOE, nvramWE, nvramCE);
    end
  endtask

  task automatic test_async_reset;
    wrValid = 1'b1; wrAddr = 15'h0AAA; wrData = 8'h5A; wrBuf = 1'b0;
    tick();
    wrAddr = 15'h0BBB; wrData = 8'h6B; wrBuf = 1'b1;
    tick();
    wrValid = 1'b0;
    @(negedge pixClk); #1;
    total++;
    if ({nvramWE, nvramCE} !== {1'b0, 2'b10}) begin
      bad++;
      $display("FAIL async_reset precondition got we=%b ce=%b expected 0/10", nvramWE, nvramCE);
    end
    #2 nReset = 1'b0;
    #1;
    total++;
    if ({nvramWE, nvramCE, vramDoe, nvramOE, vramAddr} !== {1'b1, 2'b11, 1'b0, 1'b1, 15'd0}) begin
      bad++;
      $display("FAIL async_reset immediate got we=%b ce=%b doe=%b oe=%b addr=%h expected 1/11/0/1/0",
               nvramWE, nvramCE, vramDoe, nvramOE, vramAddr);
    end
    #2 nReset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({nvramCE, vramDoe, wrReady} !== {2'b11, 1'b0, 1'b1}) begin
        bad++;
        $display("FAIL async_reset queue_discarded[%0d] got ce=%b doe=%b rdy=%b expected 11/0/1",
                 i, nvramCE, vramDoe, wrReady);
      end
    end
  endtask

  task automatic test_read_priority;
    logic [14:0] ea [3];
    logic [7:0]  ed [3];
    logic        eb [3];
    ea = '{15'h0010, 15'h0020, 15'h0030};
    ed = '{8'h11, 8'h22, 8'h33};
    eb = '{1'b0, 1'b1, 1'b0};
    seq = SLOT; vidReq = 1'b1; vidAddr = 15'h0100; vidBufSel = 1'b0; vramDin = 8'h77;
    for (int i = 0; i < 3; i++) begin
      wrValid = 1'b1; wrAddr = ea[i]; wrData = ed[i]; wrBuf = eb[i];
      tick();
    end
    wrValid = 1'b0; vidAddr = 15'h0200; vidBufSel = 1'b1;
    tick();
    total++;
    if ({vramAddr, vramDoe, nvramOE, nvramCE, wrReady} !== {15'h0200, 1'b0, 1'b0, 2'b01, 1'b1}) begin
      bad++;
      $display("FAIL read_priority read_cycle got addr=%h doe=%b oe=%b ce=%b rdy=%b expected 0200/0/0/01/1",
               vramAddr, vramDoe, nvramOE, nvramCE, wrReady);
    end
    vramDin = 8'h3C; vidReq = 1'b0; seq = 3'd5;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i < 2) begin
        total++;
        if ({vidData, vidValid} !== {8'h3C, (i == 0)}) begin
          bad++;
          $display("FAIL read_priority vid[%0d] got data=%h valid=%b expected 3c/%b",
                   i, vidData, vidValid, (i == 0));
        end
      end
      total++;
      if ({vramAddr, vramDout, vramDoe, nvramOE, nvramCE} !==
          {ea[i], ed[i], 1'b1, 1'b1, (eb[i] ? 2'b01 : 2'b10)}) begin
        bad++;
        $display("FAIL read_priority write[%0d] got addr=%h dout=%h doe=%b ce=%b expected %h/%h/1/%b",
                 i, vramAddr, vramDout, vramDoe, nvramCE, ea[i], ed[i], (eb[i] ? 2'b01 : 2'b10));
      end else $display("write %h <= %h resumed after read", ea[i], ed[i]);
    end
    tick();
    total++;
    if ({nvramCE, vramDoe} !== {2'b11, 1'b0}) begin
      bad++;
      $display("FAIL read_priority idle_after got ce=%b doe=%b expected 11/0", nvramCE, vramDoe);
    end
  endtask

  task automatic test_overflow;
    pulse_reset();
    seq = SLOT; vidReq = 1'b1; vidAddr = 15'd0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (wrReady !== (i < 4)) begin
        bad++;
        $display("FAIL overflow ready[%0d] got=%b expected=%b", i, wrReady, (i < 4));
      end
      wrValid = 1'b1; wrAddr = 15'(15'h0100 + i); wrData = 8'(8'hC0 + i); wrBuf = 1'(i % 2);
      tick();
    end
    wrValid = 1'b0; vidReq = 1'b0; seq = 3'd5;
    total++;
    if (wrOverflow !== 1'b1) begin
      bad++;
      $display("FAIL overflow flag got=%b expected=1", wrOverflow);
    end
    for (int j = 0; j < 4; j++) begin
      tick();
      total++;
      if ({vramAddr, vramDout, nvramCE} !== {15'(15'h0100 + j), 8'(8'hC0 + j), ((j % 2) ? 2'b01 : 2'b10)}) begin
        bad++;
        $display("FAIL overflow drain[%0d] got addr=%h dout=%h ce=%b expected %h/%h",
                 j, vramAddr, vramDout, nvramCE, 15'(15'h0100 + j), 8'(8'hC0 + j));
      end else $display("write %h <= %h drained", vramAddr, vramDout);
    end
    tick();
    total++;
    if ({nvramCE, vramDoe, wrOverflow, wrReady} !== {2'b11, 1'b0, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL overflow after got ce=%b doe=%b ovf=%b rdy=%b expected 11/0/1/1",
               nvramCE, vramDoe, wrOverflow, wrReady);
    end
  endtask

  task automatic test_pop_push_full;
    pulse_reset();
    total++;
    if (wrOverflow !== 1'b0) begin
      bad++;
      $display("FAIL pop_push overflow_cleared got=%b expected=0", wrOverflow);
    end
    seq = SLOT; vidReq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wrValid = 1'b1; wrAddr = 15'(15'h0200 + i); wrData = 8'(8'hD0 + i); wrBuf = 1'((i + 1) % 2);
      tick();
    end
    vidReq = 1'b0; seq = 3'd5;
    wrAddr = 15'h7FFF; wrData = 8'hEE; wrBuf = 1'b1;
    total++;
    if (wrReady !== 1'b0) begin
      bad++;
      $display("FAIL pop_push ready_at_full got=%b expected=0", wrReady);
    end
    tick();
    wrValid = 1'b0;
    total++;
    if (wrReady !== 1'b1) begin
      bad++;
      $display("FAIL pop_push count_after got ready=%b expected=1", wrReady);
    end
    for (int j = 0; j < 4; j++) begin
      if (j > 0) tick();
      total++;
      if ({vramAddr, vramDout} !== {15'(15'h0200 + j), 8'(8'hD0 + j)}) begin
        bad++;
        $display("FAIL pop_push drain[%0d] got addr=%h dout=%h expected %h/%h",
                 j, vramAddr, vramDout, 15'(15'h0200 + j), 8'(8'hD0 + j));
      end else $display("write %h <= %h drained", vramAddr, vramDout);
    end
    tick();
    total++;
    if ({nvramCE, vramDoe, wrOverflow} !== {2'b11, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL pop_push dropped_entry got ce=%b doe=%b ovf=%b addr=%h expected 11/0/1",
               nvramCE, vramDoe, wrOverflow, vramAddr);
    end
  endtask

  task automatic test_wide;
    logic [15:0] wd [4];
    logic [3:0]  ce;
    wd = '{16'h1234, 16'hABCD, 16'h8001, 16'hFFFE};
    for (int i = 0; i < 6; i++) begin
      b_wrValid = (i < 4);
      if (i < 4) begin
        b_wrAddr = 15'(15'h0300 + i); b_wrData = wd[i]; b_wrBuf = 2'(i);
      end
      tick();
      if (i >= 1 && i <= 4) begin
        ce = 4'b1111;
        ce[i - 1] = 1'b0;
        total++;
        if ({b_vramAddr, b_vramDout, b_vramDoe, b_nvramCE} !== {15'(15'h0300 + i - 1), wd[i - 1], 1'b1, ce}) begin
          bad++;
          $display("FAIL wide write[%0d] got addr=%h dout=%h doe=%b ce=%b expected %h/%h/1/%b",
                   i - 1, b_vramAddr, b_vramDout, b_vramDoe, b_nvramCE, 15'(15'h0300 + i - 1), wd[i - 1], ce);
        end else $display("wide write %h <= %h ce=%b", b_vramAddr, b_vramDout, b_nvramCE);
        if (i == 3) begin
          @(negedge pixClk); #1;
          total++;
          if (b_nvramWE !== 1'b0) begin
            bad++;
            $display("FAIL wide we_low got=%b expected=0", b_nvramWE);
          end
        end
      end
    end
    total++;
    if ({b_nvramCE, b_vramDoe} !== {4'b1111, 1'b0}) begin
      bad++;
      $display("FAIL wide idle_after got ce=%b doe=%b expected 1111/0", b_nvramCE, b_vramDoe);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_async_reset();
    test_read_priority();
    test_overflow();
    test_pop_push_full();
    idle_inputs();
    test_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
